// File: rtl/hit_cb_pkg.sv
// Shared types, default widths and parity helper for the hit circular buffer.
package hit_cb_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 7;

    typedef enum logic {
        StIdle,
        StRead
    } state_e;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic calc_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/hit_cb_mem.sv
// Flop-based DEPTH x WIDTH storage: one write port, one registered read port, async clear.
module hit_cb_mem #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Non-blocking read returns pre-write content on a same-edge collision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/hit_cb_ring_buffer.sv
// ETROC2 hit circular buffer with L1A window readout.
// Optional stored-word parity check enabled by defining HIT_CB_PARITY_EN.
module hit_cb_ring_buffer
    import hit_cb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned WIN_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] latency,
    input  logic [WIN_WIDTH-1:0]  win_len,
    input  logic                  l1a,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic                  busy,
    output logic                  l1a_drop,
    output logic [ADDR_WIDTH-1:0] wr_ptr
`ifdef HIT_CB_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

`ifdef HIT_CB_PARITY_EN
    localparam int unsigned MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int unsigned MEM_WIDTH = DATA_WIDTH;
`endif

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [WIN_WIDTH-1:0]  r_remain;
    logic                  r_dout_valid;
    logic                  r_dout_last;
    logic                  r_l1a_drop;

    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [WIN_WIDTH-1:0]  w_first_n;
    logic                  w_start;
    logic                  w_rd_en;
    logic                  w_rd_last;
    logic [MEM_WIDTH-1:0]  w_wdata;
    logic [MEM_WIDTH-1:0]  w_rdata;

    assign w_base    = r_wr_ptr - latency;
    assign w_first_n = (win_len == '0) ? '0 : win_len - WIN_WIDTH'(1);
    assign w_start   = (r_state == StIdle) && l1a;
    assign w_rd_en   = w_start || (r_state == StRead);
    assign w_rd_addr = (r_state == StRead) ? r_rd_ptr : w_base;
    assign w_rd_last = w_start ? (w_first_n == '0) : ((r_state == StRead) && (r_remain == '0));

`ifdef HIT_CB_PARITY_EN
    assign w_wdata    = {calc_parity(64'(din)), din};
    assign parity_err = r_dout_valid &&
                        (calc_parity(64'(w_rdata[DATA_WIDTH-1:0])) != w_rdata[DATA_WIDTH]);
`else
    assign w_wdata    = din;
`endif

    hit_cb_mem #(
        .WIDTH      (MEM_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_remain     <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_l1a_drop   <= 1'b0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            r_dout_valid <= w_rd_en;
            r_dout_last  <= w_rd_last;
            r_l1a_drop   <= (r_state == StRead) && l1a;
            case (r_state)
                StIdle: begin
                    // First word is read in the l1a cycle; single-word windows never leave idle.
                    if (l1a && (w_first_n != '0)) begin
                        r_rd_ptr <= w_base + ADDR_WIDTH'(1);
                        r_remain <= w_first_n - WIN_WIDTH'(1);
                        r_state  <= StRead;
                    end
                end
                StRead: begin
                    if (r_remain == '0) begin
                        r_state <= StIdle;
                    end else begin
                        r_remain <= r_remain - WIN_WIDTH'(1);
                        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign dout       = w_rdata[DATA_WIDTH-1:0];
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign busy       = w_rd_en;
    assign l1a_drop   = r_l1a_drop;
    assign wr_ptr     = r_wr_ptr;

endmodule

// File: tb/tb_hit_cb_ring_buffer.sv
// Randomized self-checking bench for hit_cb_ring_buffer against a queue-based reference model.
module tb_hit_cb_ring_buffer;

    localparam int DEPTH = 128;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] din;
    logic [6:0] latency;
    logic [1:0] win_len;
    logic       l1a;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_last;
    logic       busy;
    logic       l1a_drop;
    logic [6:0] wr_ptr;
`ifdef HIT_CB_PARITY_EN
    logic       parity_err;
`endif

    hit_cb_ring_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .din        (din),
        .latency    (latency),
        .win_len    (win_len),
        .l1a        (l1a),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .busy       (busy),
        .l1a_drop   (l1a_drop),
        .wr_ptr     (wr_ptr)
`ifdef HIT_CB_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: memory image, write pointer, queue of addresses still to be read.
    logic [7:0] mem_m [DEPTH];
    logic       bad_m [DEPTH];
    int         wp_m;
    int         pend[$];
    logic [7:0] exp_dout;
    logic       exp_valid;
    logic       exp_last;
    logic       exp_drop;
    logic       exp_perr;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = 8'h00;
            bad_m[i] = 1'b0;
        end
        wp_m = 0;
        pend.delete();
        exp_dout  = 8'h00;
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        exp_drop  = 1'b0;
        exp_perr  = 1'b0;
    endtask

    task automatic cycle(input logic we, input logic [7:0] d, input logic l,
                         input logic [6:0] lat, input logic [1:0] wl);
        logic drop_n;
        int   n;
        int   base;
        int   a;
        wr_en   = we;
        din     = d;
        l1a     = l;
        latency = lat;
        win_len = wl;
        @(negedge clk);
        chk("dout", 32'(dout), 32'(exp_dout));
        chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
        chk("dout_last", 32'(dout_last), 32'(exp_last));
        chk("l1a_drop", 32'(l1a_drop), 32'(exp_drop));
        chk("wr_ptr", 32'(wr_ptr), 32'(wp_m));
`ifdef HIT_CB_PARITY_EN
        chk("parity_err", 32'(parity_err), 32'(exp_perr));
`endif
        drop_n = l && (pend.size() > 0);
        if (l && pend.size() == 0) begin
            n    = (wl == 2'd0) ? 1 : int'(wl);
            base = (((wp_m - int'(lat)) % DEPTH) + DEPTH) % DEPTH;
            for (int i = 0; i < n; i++) pend.push_back((base + i) % DEPTH);
        end
        chk("busy", 32'(busy), 32'(pend.size() > 0));
        if (pend.size() > 0) begin
            a         = pend.pop_front();
            exp_dout  = mem_m[a];
            exp_valid = 1'b1;
            exp_last  = (pend.size() == 0);
            exp_perr  = bad_m[a];
        end else begin
            exp_valid = 1'b0;
            exp_last  = 1'b0;
            exp_perr  = 1'b0;
        end
        exp_drop = drop_n;
        if (we) begin
            mem_m[wp_m] = d;
            bad_m[wp_m] = 1'b0;
            wp_m        = (wp_m + 1) % DEPTH;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 7'd0, 2'd1);
    endtask

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        din     = 8'h00;
        l1a     = 1'b0;
        latency = 7'd0;
        win_len = 2'd1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_wr_ptr", 32'(wr_ptr), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Fill 0x00..0x7F, single-word window 10 behind wr_ptr=0.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 7'd10, 2'd1);
        cycle(1'b0, 8'h00, 1'b1, 7'd10, 2'd1);
        idle(1);
        chk("tp1_dout_hold", 32'(dout), 32'h76);

        // Three-word window wrapping 127 -> 0, with a dropped second l1a.
        cycle(1'b1, 8'h80, 1'b0, 7'd2, 2'd3);
        cycle(1'b0, 8'h00, 1'b1, 7'd2, 2'd3);
        cycle(1'b0, 8'h00, 1'b1, 7'd2, 2'd3);
        idle(4);
        chk("tp2_last_word", 32'(dout), 32'h01);

        // latency=0 collision returns the old word at address 5.
        for (int i = 1; i < 5; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 7'd0, 2'd1);
        cycle(1'b1, 8'hAA, 1'b1, 7'd0, 2'd1);
        idle(1);
        chk("tp4_collision", 32'(dout), 32'h05);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 4) == 0),
                  7'($urandom), 2'($urandom));
        end
        idle(4);

        // Reset asserted while the second word of a window is being read.
        cycle(1'b1, 8'h5A, 1'b1, 7'd3, 2'd3);
        wr_en = 1'b0;
        l1a   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(dout), 32'h0);
        chk("mid_rst_valid", 32'(dout_valid), 32'h0);
        chk("mid_rst_last", 32'(dout_last), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_drop", 32'(l1a_drop), 32'h0);
        chk("mid_rst_wr_ptr", 32'(wr_ptr), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 7'($urandom), 2'd3);
            idle(3);
        end
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 1) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
                  7'($urandom), 2'($urandom));
        end
        idle(4);

`ifdef HIT_CB_PARITY_EN
        // Corrupt one stored bit at address 20, then read 20..22.
        for (int i = 0; i < 32; i++) cycle(1'b1, 8'($urandom), 1'b0, 7'd0, 2'd1);
        dut.u_mem.r_mem[20] = dut.u_mem.r_mem[20] ^ 9'h001;
        mem_m[20] = mem_m[20] ^ 8'h01;
        bad_m[20] = 1'b1;
        cycle(1'b0, 8'h00, 1'b1, 7'((wp_m - 20 + DEPTH) % DEPTH), 2'd3);
        idle(4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
